// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, bit timing helper and
// frame geometry, common to the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } uart_tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the transmitter; first-word-fall-through, so pop_data
// always shows the oldest entry whenever the FIFO is non-empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] push_data,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == (AW + 1)'(DEPTH));
    empty    = (count == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: buffers bytes from a valid/ready stream and shifts them
// out as 8N1 frames, LSB first, back-to-back while the FIFO holds data.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] LAST_CLK     = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state_q, state_d;
  logic [15:0]    clock_count_q, clock_count_d;
  logic [2:0]     bit_index_q, bit_index_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_rd_data;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_valid),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .pop_data (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;

  // The line level is registered from the current state, so tx trails the
  // state register by one cycle while every bit still lasts CLKS_PER_BIT.
  always_comb begin
    state_d       = state_q;
    clock_count_d = clock_count_q;
    bit_index_d   = bit_index_q;
    shift_d       = shift_q;
    fifo_pop      = 1'b0;
    tx_d          = 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_d       = fifo_rd_data;
          clock_count_d = '0;
          bit_index_d   = '0;
          state_d       = START_BIT;
        end
      end
      START_BIT: begin
        tx_d = 1'b0;
        if (clock_count_q == LAST_CLK) begin
          clock_count_d = '0;
          state_d       = DATA_BITS;
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end
      DATA_BITS: begin
        tx_d = shift_q[bit_index_q];
        if (clock_count_q == LAST_CLK) begin
          clock_count_d = '0;
          if (bit_index_q == LAST_BIT) begin
            state_d = STOP_BIT;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end
      STOP_BIT: begin
        tx_d = 1'b1;
        if (clock_count_q == LAST_CLK) begin
          clock_count_d = '0;
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            shift_d     = fifo_rd_data;
            bit_index_d = '0;
            state_d     = START_BIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clock_count_d = clock_count_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    // state_q term covers the stop bit still on the lagging tx register;
    // a non-empty FIFO in IDLE always pops, so state_d covers the drain case.
    busy_d = (state_d != IDLE) || (state_q != IDLE) || !fifo_empty ||
             (tx_valid && !fifo_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      clock_count_q <= '0;
      bit_index_q   <= '0;
      shift_q       <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      clock_count_q <= clock_count_d;
      bit_index_q   <= bit_index_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
    end
  end

endmodule
